pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter WAIT_MAX, default 255, SHALL set the data-memory wait cycles tolerated before the error state.
REQ-002 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n_i  in  1  asynchronous, active-low reset.
REQ-004 start_i  in  1  run enable; low SHALL freeze the pipeline.
REQ-005 IDEX_MemRead_i  in  1  instruction in EX is a load.
REQ-006 IDEX_Rd_Addr_i  in  5  destination register of the instruction in EX.
REQ-007 IFID_RS1_Addr_i, IFID_RS2_Addr_i  in  5 each  source registers of the instruction in ID.
REQ-008 Branch_taken_i  in  1  branch resolved taken in ID.
REQ-009 EXMEM_MemReq_i  in  1  the MEM stage holds a load or store.
REQ-010 DMem_Ready_i  in  1  data memory completes the MEM access this cycle.
REQ-011 PCWrite_o, IFID_Write_o, IDEX_Enable_o, EXMEM_Enable_o, MEMWB_Enable_o  out  1 each  per-stage advance enables; IDEX_Enable_o drives the start_i port of the ID/EX register.
REQ-012 IDEX_Bubble_o  out  1  forces all ID/EX control inputs to zero.
REQ-013 IFID_Flush_o  out  1  loads a NOP into IF/ID.
REQ-014 Err_o  out  1  sticky memory-timeout flag.
REQ-015 Cycle_Cnt_o, Stall_Cnt_o  out  32 each  performance counters.

Function
REQ-016 The FSM SHALL have four states: IDLE, RUN, MEM_WAIT and ERROR.
REQ-017 IDLE SHALL hold all enables, IDEX_Bubble_o and IFID_Flush_o at 0, and SHALL move to RUN on the edge where start_i=1.
REQ-018 RUN with start_i=0 SHALL move to IDLE; start_i is evaluated before every other condition.
REQ-019 A mem wait SHALL be detected in RUN when EXMEM_MemReq_i=1 and DMem_Ready_i=0.
REQ-020 On a mem wait, all five enables SHALL be 0 in the same cycle (combinational), and the FSM SHALL enter MEM_WAIT.
REQ-021 MEM_WAIT SHALL hold all enables at 0 until DMem_Ready_i=1.
REQ-022 In the cycle DMem_Ready_i=1 during MEM_WAIT, all enables SHALL be 1 and the next state SHALL be RUN.
REQ-023 A load-use hazard SHALL be detected when IDEX_MemRead_i=1, IDEX_Rd_Addr_i!=0, and IDEX_Rd_Addr_i equals either IFID source address.
REQ-024 A load-use hazard in RUN without a mem wait SHALL give, in the same cycle: PCWrite_o=0, IFID_Write_o=0, IDEX_Bubble_o=1, and the other enables at 1. The stall lasts one cycle per detection.
REQ-025 Branch_taken_i=1 in RUN without a mem wait or load-use hazard SHALL give IFID_Flush_o=1 for one cycle with all enables at 1.
REQ-026 Priority SHALL be: start_i low > mem wait > load-use > branch flush. A lower-priority event is ignored in a cycle where a higher one applies.
REQ-027 A wait counter SHALL clear on entry to MEM_WAIT and increment each cycle spent in MEM_WAIT.
REQ-028 When the wait counter reaches WAIT_MAX with DMem_Ready_i=0, the FSM SHALL enter ERROR.
REQ-029 ERROR SHALL hold all enables at 0, set Err_o=1, and be left only by reset.
REQ-030 start_i=0 during MEM_WAIT SHALL be ignored until the access completes.
REQ-031 Cycle_Cnt_o SHALL increment in every cycle where the state is not IDLE and not ERROR.
REQ-032 Stall_Cnt_o SHALL increment in every such cycle where PCWrite_o=0.
REQ-033 Both counters SHALL saturate at 32'hFFFFFFFF.

Reset
REQ-034 rst_n_i low SHALL, immediately and independent of the clock, set state=IDLE, clear all counters, and set Err_o=0.
REQ-035 While rst_n_i is low, all enables, IDEX_Bubble_o and IFID_Flush_o SHALL be 0; an access in flight during reset is abandoned.

Structure
REQ-036 The FSM state encoding, WAIT_MAX default and the x0 register address constant SHALL live in the shared pipeline package.
REQ-037 The combinational load-use comparator SHALL be a sub-module named hazard_detect; all other logic SHALL stay in pipeline_ctrl.

Verification
REQ-038 Scenario: reset, then start_i=1 -> IDLE to RUN; all enables 1 on the next cycle; Cycle_Cnt_o=1 after the first RUN edge.
REQ-039 Scenario: IDEX_MemRead_i=1, Rd=5, RS2=5 -> PCWrite_o=0, IFID_Write_o=0, IDEX_Bubble_o=1 for one cycle; Stall_Cnt_o increments by 1. With Rd=0 -> no stall.
REQ-040 Scenario: EXMEM_MemReq_i=1, DMem_Ready_i low for 3 cycles then high -> enables 0 for 3 cycles, 1 in the ready cycle; Stall_Cnt_o increases by 3.
REQ-041 Scenario: Branch_taken_i and a load-use hazard in the same cycle -> stall only, IFID_Flush_o=0. Branch_taken_i alone -> IFID_Flush_o=1 for one cycle.
REQ-042 Scenario: WAIT_MAX=4, DMem_Ready_i held low -> ERROR with Err_o=1 after 4 wait cycles; counters frozen; only rst_n_i recovers.
REQ-043 Scenario: rst_n_i asserted mid MEM_WAIT -> outputs 0 without waiting for a clock edge; after release, state=IDLE with counters at 0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM states, stage-enable bundle,
// tunable defaults and the saturating counter helper.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_ERROR    = 2'd3
    } pipe_state_e;

    localparam int unsigned WAIT_MAX_DEFAULT = 255;
    localparam logic [4:0]  REG_X0           = 5'd0;
    localparam logic [31:0] CNT_MAX          = '1;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic idex_enable;
        logic exmem_enable;
        logic memwb_enable;
    } stage_en_t;

    localparam stage_en_t EN_NONE = '0;
    localparam stage_en_t EN_ALL  = '1;
    // Load-use stall: hold PC and IF/ID, let the bubble and older stages drain.
    localparam stage_en_t EN_LOAD_USE = '{
        pc_write:     1'b0,
        ifid_write:   1'b0,
        idex_enable:  1'b1,
        exmem_enable: 1'b1,
        memwb_enable: 1'b1
    };

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == CNT_MAX) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use comparator: the load in EX writes a register the instruction in ID reads.
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic       memread_i,
    input  logic [4:0] rd_addr_i,
    input  logic [4:0] rs1_addr_i,
    input  logic [4:0] rs2_addr_i,
    output logic       hazard_o
);

    always_comb begin
        hazard_o = memread_i
                && (rd_addr_i != REG_X0)
                && ((rd_addr_i == rs1_addr_i) || (rd_addr_i == rs2_addr_i));
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: stage enables, bubble/flush requests,
// data-memory timeout detection and performance counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_MAX = WAIT_MAX_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic        IDEX_MemRead_i,
    input  logic [4:0]  IDEX_Rd_Addr_i,
    input  logic [4:0]  IFID_RS1_Addr_i,
    input  logic [4:0]  IFID_RS2_Addr_i,
    input  logic        Branch_taken_i,
    input  logic        EXMEM_MemReq_i,
    input  logic        DMem_Ready_i,
    output logic        PCWrite_o,
    output logic        IFID_Write_o,
    output logic        IDEX_Enable_o,
    output logic        EXMEM_Enable_o,
    output logic        MEMWB_Enable_o,
    output logic        IDEX_Bubble_o,
    output logic        IFID_Flush_o,
    output logic        Err_o,
    output logic [31:0] Cycle_Cnt_o,
    output logic [31:0] Stall_Cnt_o
);

    pipe_state_e state_q, state_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        err_q, err_d;

    stage_en_t   en;
    logic        bubble;
    logic        flush;
    logic        load_use;
    logic        mem_wait;
    logic        active;

    hazard_detect u_hazard_detect (
        .memread_i  (IDEX_MemRead_i),
        .rd_addr_i  (IDEX_Rd_Addr_i),
        .rs1_addr_i (IFID_RS1_Addr_i),
        .rs2_addr_i (IFID_RS2_Addr_i),
        .hazard_o   (load_use)
    );

    assign mem_wait = EXMEM_MemReq_i && !DMem_Ready_i;

    // Enables are decoded from the current state and live inputs so a stall
    // takes effect in the very cycle its cause is seen.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
        en         = EN_NONE;
        bubble     = 1'b0;
        flush      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!start_i) begin
                    state_d = ST_IDLE;
                end else if (mem_wait) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = '0;
                end else if (load_use) begin
                    en     = EN_LOAD_USE;
                    bubble = 1'b1;
                end else begin
                    en    = EN_ALL;
                    flush = Branch_taken_i;
                end
            end
            ST_MEM_WAIT: begin
                if (DMem_Ready_i) begin
                    en      = EN_ALL;
                    state_d = ST_RUN;
                end else begin
                    wait_cnt_d = wait_cnt_q + 32'd1;
                    if (wait_cnt_d == WAIT_MAX) begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_ERROR: begin
                err_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        active      = (state_q == ST_RUN) || (state_q == ST_MEM_WAIT);
        cycle_cnt_d = active ? sat_inc(cycle_cnt_q) : cycle_cnt_q;
        stall_cnt_d = (active && !en.pc_write) ? sat_inc(stall_cnt_q) : stall_cnt_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            cycle_cnt_q <= '0;
            stall_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            err_q       <= err_d;
        end
    end

    assign PCWrite_o      = en.pc_write;
    assign IFID_Write_o   = en.ifid_write;
    assign IDEX_Enable_o  = en.idex_enable;
    assign EXMEM_Enable_o = en.exmem_enable;
    assign MEMWB_Enable_o = en.memwb_enable;
    assign IDEX_Bubble_o  = bubble;
    assign IFID_Flush_o   = flush;
    assign Err_o          = err_q;
    assign Cycle_Cnt_o    = cycle_cnt_q;
    assign Stall_Cnt_o    = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios then randomized traffic, all
// checked against a cycle-level behavioural model of the controller rules.
module tb_pipeline_ctrl;

    localparam int unsigned TB_WAIT_MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        memread;
    logic [4:0]  rd, rs1, rs2;
    logic        branch;
    logic        memreq;
    logic        ready;
    logic        pc_w, ifid_w, idex_en, exmem_en, memwb_en, bubble, flush, err;
    logic [31:0] cyc_cnt, stl_cnt;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit     m_on;
    bit     m_wait;
    bit     m_err;
    int     m_waited;
    longint m_cycles;
    longint m_stalls;

    always #5 clk = ~clk;

    pipeline_ctrl #(.WAIT_MAX(TB_WAIT_MAX)) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .start_i         (start),
        .IDEX_MemRead_i  (memread),
        .IDEX_Rd_Addr_i  (rd),
        .IFID_RS1_Addr_i (rs1),
        .IFID_RS2_Addr_i (rs2),
        .Branch_taken_i  (branch),
        .EXMEM_MemReq_i  (memreq),
        .DMem_Ready_i    (ready),
        .PCWrite_o       (pc_w),
        .IFID_Write_o    (ifid_w),
        .IDEX_Enable_o   (idex_en),
        .EXMEM_Enable_o  (exmem_en),
        .MEMWB_Enable_o  (memwb_en),
        .IDEX_Bubble_o   (bubble),
        .IFID_Flush_o    (flush),
        .Err_o           (err),
        .Cycle_Cnt_o     (cyc_cnt),
        .Stall_Cnt_o     (stl_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sat32(input longint v);
        return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
    endfunction

    // Expected {5 enables, bubble, flush} for the current inputs and model state.
    function automatic logic [6:0] model_out();
        bit hz;
        hz = memread && (rd != 0) && (rd == rs1 || rd == rs2);
        if (m_err || !m_on)            return 7'b00000_00;
        if (m_wait)                    return ready ? 7'b11111_00 : 7'b00000_00;
        if (!start)                    return 7'b00000_00;
        if (memreq && !ready)          return 7'b00000_00;
        if (hz)                        return 7'b00111_10;
        return {5'b11111, 1'b0, branch};
    endfunction

    task automatic model_edge(input logic [6:0] o);
        if (m_on && !m_err) begin
            m_cycles++;
            if (!o[6]) m_stalls++;
        end
        if (m_err) begin
        end else if (!m_on) begin
            if (start) m_on = 1;
        end else if (m_wait) begin
            if (ready) m_wait = 0;
            else begin
                m_waited++;
                if (m_waited == TB_WAIT_MAX) begin
                    m_err  = 1;
                    m_wait = 0;
                end
            end
        end else if (!start) begin
            m_on = 0;
        end else if (memreq && !ready) begin
            m_wait   = 1;
            m_waited = 0;
        end
    endtask

    task automatic model_reset();
        m_on = 0; m_wait = 0; m_err = 0; m_waited = 0;
        m_cycles = 0; m_stalls = 0;
    endtask

    task automatic check_regs();
        chk("cycle_cnt", cyc_cnt, sat32(m_cycles));
        chk("stall_cnt", stl_cnt, sat32(m_stalls));
        chk("err", {31'd0, err}, {31'd0, m_err});
    endtask

    // Called just after a falling edge; returns at the next falling edge.
    task automatic step(input logic st, input logic mr, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic br, input logic mq, input logic rdy);
        logic [6:0] e;
        check_regs();
        start = st; memread = mr; rd = d; rs1 = s1; rs2 = s2;
        branch = br; memreq = mq; ready = rdy;
        #1;
        e = model_out();
        chk("enables", {27'd0, pc_w, ifid_w, idex_en, exmem_en, memwb_en}, {27'd0, e[6:2]});
        chk("bubble", {31'd0, bubble}, {31'd0, e[1]});
        chk("flush", {31'd0, flush}, {31'd0, e[0]});
        model_edge(e);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        start = 0; memread = 0; rd = 0; rs1 = 0; rs2 = 0;
        branch = 0; memreq = 0; ready = 0;
    endtask

    // Asserts reset between edges and checks it acts without a clock.
    task automatic apply_reset();
        #1 rst_n = 0;
        #1;
        model_reset();
        chk("rst_enables", {27'd0, pc_w, ifid_w, idex_en, exmem_en, memwb_en}, 32'd0);
        chk("rst_bubble_flush", {30'd0, bubble, flush}, 32'd0);
        check_regs();
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        logic [4:0] r_rd, r_s1, r_s2;
        rst_n = 0;
        clear_inputs();
        model_reset();
        @(negedge clk);
        apply_reset();

        // Start-up: IDLE holds everything off, then RUN enables all stages
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 1);
        chk("cycle_after_first_run", cyc_cnt, 32'd1);

        // Load-use on RS2, then Rd = x0 which must not stall
        step(1, 1, 5, 1, 5, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0, 0, 0, 1);
        step(1, 1, 7, 7, 2, 0, 0, 1);

        // Branch with hazard: stall wins; branch alone flushes
        step(1, 1, 3, 3, 0, 1, 0, 1);
        step(1, 0, 0, 0, 0, 1, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 1);

        // Memory wait for three cycles, ready on the fourth
        step(1, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 1, 0);
        step(1, 1, 4, 4, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 1, 1);
        step(1, 0, 0, 0, 0, 0, 0, 1);

        // Start low in RUN returns to IDLE
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);

        // Timeout into ERROR; nothing but reset leaves it
        step(1, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0, 0, 1, 0);
        chk("err_set", {31'd0, err}, 32'd1);
        for (int i = 0; i < 4; i++) step(i[0], 0, 0, 0, 0, 1, 0, 1);
        apply_reset();

        // Asynchronous reset in the middle of a memory wait
        step(1, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 1, 0);
        ready = 1;
        #1;
        chk("wait_ready_pcwrite", {31'd0, pc_w}, 32'd1);
        apply_reset();
        step(0, 0, 0, 0, 0, 0, 0, 1);

        // Randomized traffic, restarted from reset a few times
        for (int b = 0; b < 4; b++) begin
            for (int n = 0; n < 150; n++) begin
                r_rd = 5'($urandom_range(0, 3));
                r_s1 = 5'($urandom_range(0, 3));
                r_s2 = 5'($urandom_range(0, 3));
                step($urandom_range(0, 9) != 0, 1'($urandom), r_rd, r_s1, r_s2,
                     1'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 2) != 0);
            end
            apply_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
